// File: rtl/usb4_os_pkg.sv
// Shared ordered-set codes and training-confirm state encoding for the USB4 lane receive path.
package usb4_os_pkg;

    localparam logic [3:0] OS_SLOS1  = 4'd0;
    localparam logic [3:0] OS_SLOS2  = 4'd1;
    localparam logic [3:0] OS_G3_TS1 = 4'd2;
    localparam logic [3:0] OS_G3_TS2 = 4'd3;
    localparam logic [3:0] OS_G4_TS1 = 4'd4;
    localparam logic [3:0] OS_G4_TS2 = 4'd5;
    localparam logic [3:0] OS_G4_TS3 = 4'd6;
    localparam logic [3:0] OS_G4_TS4 = 4'd7;
    localparam logic [3:0] OS_DATA   = 4'd8;
    localparam logic [3:0] OS_NONE   = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone,
        StTimeout
    } os_state_e;

    // True for codes that name a countable ordered set (SLOS or TS).
    function automatic logic is_train_os(input logic [3:0] code);
        return code <= OS_G4_TS4;
    endfunction

endpackage

// File: rtl/os_train_confirm_if.sv
// Lane-training side of os_train_confirm: OS codes in, confirmation status out.
// lane1_en exists only when OS_CONFIRM_LANE1_MASK_EN is defined.
interface os_train_confirm_if;

    logic       lane_rx_on;
    logic [3:0] d_sel;
    logic [3:0] os_in_l0;
    logic [3:0] os_in_l1;
`ifdef OS_CONFIRM_LANE1_MASK_EN
    logic       lane1_en;
`endif
    logic       os_done;
    logic       os_done_pulse;
    logic       os_timeout;
    logic [3:0] done_os;

    modport master (
        output lane_rx_on,
        output d_sel,
        output os_in_l0,
        output os_in_l1,
`ifdef OS_CONFIRM_LANE1_MASK_EN
        output lane1_en,
`endif
        input  os_done,
        input  os_done_pulse,
        input  os_timeout,
        input  done_os
    );

    modport slave (
        input  lane_rx_on,
        input  d_sel,
        input  os_in_l0,
        input  os_in_l1,
`ifdef OS_CONFIRM_LANE1_MASK_EN
        input  lane1_en,
`endif
        output os_done,
        output os_done_pulse,
        output os_timeout,
        output done_os
    );

endinterface

// File: rtl/os_lane_counter.sv
// Per-lane saturating run counter of consecutive ordered sets matching the expected code.
module os_lane_counter
    import usb4_os_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [3:0]       exp,
    input  logic [3:0]       code,
    input  logic             mask,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // No-event slots keep the run alive; any foreign code breaks it.
    always_comb begin
        cnt_nxt = '0;
        if (clr || mask) begin
            cnt_nxt = '0;
        end else if (code == exp) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end else if (code == OS_NONE) begin
            cnt_nxt = cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/os_train_confirm.sv
// Confirms that both lanes saw the required run of the selected ordered set, or times out.
// Define OS_CONFIRM_LANE1_MASK_EN to add lane1_en, which lets lane 0 alone complete the count.
module os_train_confirm
    import usb4_os_pkg::*;
#(
    parameter int unsigned REQ_SLOS    = 2,
    parameter int unsigned REQ_TS      = 8,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input logic               clk,
    input logic               rst,
    os_train_confirm_if.slave bus
);

    localparam int unsigned     TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    os_state_e        state_q, state_d;
    logic [3:0]       exp_q, exp_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             done_q, pulse_q, timeout_q;
    logic [3:0]       done_os_q;

    logic             clr, mask1;
    logic [CNT_W-1:0] req;
    logic [CNT_W-1:0] cnt0, cnt1, cnt0_nxt, cnt1_nxt;
    logic             lanes_ok;
    logic             unused_cnt;

`ifdef OS_CONFIRM_LANE1_MASK_EN
    assign mask1 = ~bus.lane1_en;
`else
    assign mask1 = 1'b0;
`endif

    // Counters only run while COUNT continues with an unchanged selection.
    assign clr      = (state_q != StCount) || !bus.lane_rx_on || (bus.d_sel != exp_q);
    assign req      = (exp_q <= OS_SLOS2) ? CNT_W'(REQ_SLOS) : CNT_W'(REQ_TS);
    assign lanes_ok = (cnt0_nxt >= req) && (mask1 || (cnt1_nxt >= req));
    assign unused_cnt = ^{cnt0, cnt1};

    os_lane_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_l0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .exp     (exp_q),
        .code    (bus.os_in_l0),
        .mask    (1'b0),
        .cnt     (cnt0),
        .cnt_nxt (cnt0_nxt)
    );

    os_lane_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_l1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .exp     (exp_q),
        .code    (bus.os_in_l1),
        .mask    (mask1),
        .cnt     (cnt1),
        .cnt_nxt (cnt1_nxt)
    );

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        if (!bus.lane_rx_on) begin
            state_d = StIdle;
            exp_d   = OS_NONE;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_train_os(bus.d_sel)) begin
                        state_d = StCount;
                        exp_d   = bus.d_sel;
                    end
                end
                default: begin
                    if (bus.d_sel != exp_q) begin
                        if (is_train_os(bus.d_sel)) begin
                            state_d = StCount;
                            exp_d   = bus.d_sel;
                        end else begin
                            state_d = StIdle;
                            exp_d   = OS_NONE;
                        end
                    end else if (state_q == StCount) begin
                        // Completion takes priority over a simultaneous expiry.
                        if (lanes_ok) begin
                            state_d = StDone;
                        end else if (timer_q == TMR_LAST) begin
                            state_d = StTimeout;
                        end
                    end
                end
            endcase
        end
        timer_d = (!clr && state_d == StCount) ? timer_q + TMR_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            exp_q     <= OS_NONE;
            timer_q   <= '0;
            done_q    <= 1'b0;
            pulse_q   <= 1'b0;
            timeout_q <= 1'b0;
            done_os_q <= OS_NONE;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            timer_q   <= timer_d;
            done_q    <= (state_d == StDone);
            pulse_q   <= (state_d == StDone) && (state_q != StDone);
            timeout_q <= (state_d == StTimeout);
            done_os_q <= (state_d == StDone) ? exp_d : OS_NONE;
        end
    end

    assign bus.os_done       = done_q;
    assign bus.os_done_pulse = pulse_q;
    assign bus.os_timeout    = timeout_q;
    assign bus.done_os       = done_os_q;

endmodule

// File: tb/tb_os_train_confirm.sv
// Vector-table bench for os_train_confirm; expected outputs queued at drive time, checked after the edge.
module tb_os_train_confirm;

    typedef struct {
        bit         r;
        bit         on;
        logic [3:0] ds;
        logic [3:0] a;
        logic [3:0] b;
        bit         en;
        bit         dn;
        bit         pl;
        bit         to;
        logic [3:0] os;
    } vec_t;

    typedef struct {
        bit         dn;
        bit         pl;
        bit         to;
        logic [3:0] os;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    os_train_confirm_if bus ();

    os_train_confirm #(
        .REQ_SLOS    (2),
        .REQ_TS      (8),
        .CNT_W       (5),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    task automatic add(input bit r, input bit on, input logic [3:0] ds, input logic [3:0] a,
                       input logic [3:0] b, input bit en, input bit dn, input bit pl,
                       input bit to, input logic [3:0] os);
        vec_t v;
        v.r = r; v.on = on; v.ds = ds; v.a = a; v.b = b; v.en = en;
        v.dn = dn; v.pl = pl; v.to = to; v.os = os;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string name);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            rst            = tbl[i].r;
            bus.lane_rx_on = tbl[i].on;
            bus.d_sel      = tbl[i].ds;
            bus.os_in_l0   = tbl[i].a;
            bus.os_in_l1   = tbl[i].b;
`ifdef OS_CONFIRM_LANE1_MASK_EN
            bus.lane1_en   = tbl[i].en;
`endif
            e.dn = tbl[i].dn; e.pl = tbl[i].pl; e.to = tbl[i].to; e.os = tbl[i].os;
            sb.push_back(e);
            @(posedge clk);
            #1;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL %s[%0d]: scoreboard empty", name, i);
            end else begin
                e = sb.pop_front();
                if (bus.os_done !== e.dn || bus.os_done_pulse !== e.pl ||
                    bus.os_timeout !== e.to || bus.done_os !== e.os) begin
                    n_bad++;
                    $display("FAIL %s[%0d]: got done=%b pulse=%b timeout=%b os=%h, want %b %b %b %h",
                             name, i, bus.os_done, bus.os_done_pulse, bus.os_timeout,
                             bus.done_os, e.dn, e.pl, e.to, e.os);
                end
            end
        end
        tbl.delete();
    endtask

    initial begin
        logic [3:0] ca, cb;
        bit         fin;
        n_cmp = 0;
        n_bad = 0;

        add(1, 0, 4'h9, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        add(1, 1, 4'h2, 4'h2, 4'h2, 1, 0, 0, 0, 4'h9);
        run_tbl("reset");

        // 8 TS1 per lane separated by no-event slots
        add(0, 1, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 15; j++) begin
            ca  = (j % 2 == 0) ? 4'h2 : 4'h9;
            fin = (j == 14);
            add(0, 1, 4'h2, ca, ca, 1, fin, fin, 0, fin ? 4'h2 : 4'h9);
        end
        add(0, 1, 4'h2, 4'h9, 4'h9, 1, 1, 0, 0, 4'h2);
        add(0, 1, 4'h2, 4'h2, 4'h3, 1, 1, 0, 0, 4'h2);
        add(0, 0, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        run_tbl("lane_count");

        add(0, 1, 4'h3, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 14; j++) begin
            ca  = (j < 8) ? 4'h3 : 4'h9;
            cb  = (j == 5) ? 4'h2 : 4'h3;
            fin = (j == 13);
            add(0, 1, 4'h3, ca, cb, 1, fin, fin, 0, fin ? 4'h3 : 4'h9);
        end
        add(0, 0, 4'h3, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        run_tbl("broken_run");

        add(0, 1, 4'h0, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 20; j++) begin
            add(0, 1, 4'h0, 4'h9, 4'h9, 1, 0, 0, j == 19, 4'h9);
        end
        add(0, 1, 4'h0, 4'h9, 4'h9, 1, 0, 0, 1, 4'h9);
        add(0, 1, 4'h8, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        add(0, 1, 4'h8, 4'h0, 4'h0, 1, 0, 0, 0, 4'h9);
        run_tbl("timeout");

        // second SLOS1 lands on the expiry cycle
        add(0, 1, 4'h0, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 20; j++) begin
            ca  = (j == 0 || j == 19) ? 4'h0 : 4'h9;
            fin = (j == 19);
            add(0, 1, 4'h0, ca, ca, 1, fin, fin, 0, fin ? 4'h0 : 4'h9);
        end
        add(0, 1, 4'h0, 4'h9, 4'h9, 1, 1, 0, 0, 4'h0);
        add(0, 0, 4'h0, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        run_tbl("timeout_race");

        add(0, 1, 4'h4, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 3; j++) add(0, 1, 4'h4, 4'h4, 4'h4, 1, 0, 0, 0, 4'h9);
        add(0, 1, 4'h5, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 8; j++) begin
            fin = (j == 7);
            add(0, 1, 4'h5, 4'h5, 4'h5, 1, fin, fin, 0, fin ? 4'h5 : 4'h9);
        end
        add(0, 1, 4'h6, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        add(0, 0, 4'h6, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        run_tbl("dsel_change");

        add(0, 1, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 5; j++) add(0, 1, 4'h2, 4'h2, 4'h2, 1, 0, 0, 0, 4'h9);
        add(0, 0, 4'h2, 4'h2, 4'h2, 1, 0, 0, 0, 4'h9);
        add(0, 1, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 8; j++) begin
            fin = (j == 7);
            add(0, 1, 4'h2, 4'h2, 4'h2, 1, fin, fin, 0, fin ? 4'h2 : 4'h9);
        end
        add(0, 0, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        run_tbl("rx_off");

        add(0, 1, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 5; j++) add(0, 1, 4'h2, 4'h2, 4'h2, 1, 0, 0, 0, 4'h9);
        add(1, 1, 4'h2, 4'h2, 4'h2, 1, 0, 0, 0, 4'h9);
        add(0, 1, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 8; j++) begin
            fin = (j == 7);
            add(0, 1, 4'h2, 4'h2, 4'h2, 1, fin, fin, 0, fin ? 4'h2 : 4'h9);
        end
        add(0, 1, 4'h2, 4'h9, 4'h9, 1, 1, 0, 0, 4'h2);
        add(1, 1, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        add(0, 0, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        run_tbl("rst_mid");

`ifdef OS_CONFIRM_LANE1_MASK_EN
        add(0, 1, 4'h2, 4'h9, 4'h9, 0, 0, 0, 0, 4'h9);
        for (int j = 0; j < 8; j++) begin
            fin = (j == 7);
            add(0, 1, 4'h2, 4'h2, 4'h9, 0, fin, fin, 0, fin ? 4'h2 : 4'h9);
        end
        add(0, 0, 4'h2, 4'h9, 4'h9, 0, 0, 0, 0, 4'h9);
        run_tbl("lane1_masked");
`endif

        add(0, 1, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 8; j++) add(0, 1, 4'h2, 4'h2, 4'h9, 1, 0, 0, 0, 4'h9);
        for (int j = 0; j < 4; j++) add(0, 1, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        add(0, 0, 4'h2, 4'h9, 4'h9, 1, 0, 0, 0, 4'h9);
        run_tbl("lane1_required");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
